permute_reg_file: RTL
=====================

PERMUTE_REG_FILE -- requirements
Module: permute_reg_file

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 7, address bits; depth = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 8, bits per entry.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state changes on rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- write_en, in, 1, external write strobe.
- address_w, in, ADDR_WIDTH, external write address.
- data_w, in, DATA_WIDTH, external write data.
- address_r, in, ADDR_WIDTH, read address.
- data_r, out, DATA_WIDTH, read data (combinational).
- op_valid, in, 1, permute-operation request.
- op_ready, out, 1, block idle and accepting an operation.
- op_mode, in, 2, operation: 00 SWAP A<->B, 01 COPY A->B, 10 CLEAR B, 11 reserved.
- address_A, in, ADDR_WIDTH, operand address A.
- address_B, in, ADDR_WIDTH, operand address B.
- op_done, out, 1, one-cycle completion pulse.
- op_err, out, 1, one-cycle pulse coincident with op_done for reserved mode.
- wr_drop, out, 1, one-cycle pulse when an external write is discarded.

Function
REQ-003 The storage array SHALL hold 2**ADDR_WIDTH words of DATA_WIDTH bits.
REQ-004 The FSM SHALL have exactly three states, IDLE, LATCH and COMMIT; op_ready = 1 only in IDLE.
REQ-005 An operation SHALL be accepted on an edge with op_valid=1 and op_ready=1; op_mode, address_A and address_B SHALL be registered at that edge; next state LATCH.
REQ-006 In LATCH, the next edge SHALL capture mem[A] into tmp_A and mem[B] into tmp_B; next state COMMIT.
REQ-007 In COMMIT, the next edge SHALL apply the operation; next state IDLE.
- SWAP: mem[A]<=tmp_B, mem[B]<=tmp_A.
- COPY: mem[B]<=tmp_A.
- CLEAR: mem[B]<=0.
- Reserved mode: no array change.
REQ-008 op_done SHALL be 1 for exactly the cycle following the COMMIT edge; op_err likewise, only for mode 11.
REQ-009 Latency from accept edge to array update SHALL be 2 edges; maximum throughput is one operation per 3 cycles; op_valid while busy SHALL be ignored, not queued.
REQ-010 An accept may occur in the same cycle that op_done is high (back-to-back).
REQ-011 With address_A == address_B, SWAP and COPY SHALL leave the array unchanged and complete normally; CLEAR SHALL zero that entry.
REQ-012 An external write with op_ready=1 SHALL update mem[address_w]<=data_w at the edge.
REQ-013 An external write with op_ready=0 SHALL be discarded, and wr_drop SHALL pulse for one cycle after that edge; this keeps operations atomic.
REQ-014 When an external write and an accept occur on the same edge, the write SHALL land first, and LATCH SHALL observe the written value.
REQ-015 data_r SHALL equal mem[address_r] combinationally, reflecting array contents after the most recent edge.

Reset
REQ-016 While reset_n=0, the block SHALL asynchronously set:
- state=IDLE.
- all array words, tmp_A and tmp_B to 0.
- op_done=0, op_err=0, wr_drop=0.
REQ-017 Reset asserted mid-operation SHALL abort it with no partial array update surviving; after release, op_ready=1 on the first cycle.

Configuration
REQ-018 Macro PERMUTE_RD_BYPASS_EN SHALL control read bypass.
- Defined: when write_en=1, op_ready=1 and address_w==address_r, data_r SHALL equal data_w combinationally (write-through bypass).
- Undefined: data_r SHALL show the old contents until the edge.
- Sequential behaviour is identical in both builds.

Verification
REQ-019 Write mem[20..29]=20..29, then SWAP A=22,B=28 -> op_done 3 cycles after accept; mem[22]=28, mem[28]=22.
REQ-020 Issue three back-to-back SWAP 22/28 with op_valid held high -> accepts every 3 cycles; final mem[22]=28, mem[28]=22.
REQ-021 COPY A=25,B=5, then CLEAR B=25 -> mem[5]=25, mem[25]=0; op_err=0 throughout.
REQ-022 Write address 40 data 0xAA while busy (LATCH), plus mode 11 -> wr_drop pulses and mem[40] is unchanged; op_err and op_done pulse together with no array change.
REQ-023 Assert reset_n=0 during COMMIT of SWAP 22/28 -> all reads 0 afterward; op_ready=1 in the first cycle after release.
REQ-024 With PERMUTE_RD_BYPASS_EN, address_r=address_w=60, data_w=0x5A, idle -> data_r=0x5A before the edge; without the macro, data_r=0 before the edge.

Source files
------------

// File: rtl/permute_reg_file.sv
// permute_reg_file
// ----------------
// Register file with an atomic permute engine. External writes go straight
// into the array while the block is idle. A permute operation (SWAP, COPY or
// CLEAR between two entries) runs through three states:
//   IDLE   -> accept the operation and register mode and addresses
//   LATCH  -> capture both operands into tmp_a / tmp_b
//   COMMIT -> write the result back into the array
// While an operation is in flight, external writes are dropped and reported
// on wr_drop, so that no write can slip in between LATCH and COMMIT.
//
// Handshake: op_valid/op_ready follow valid/ready semantics. An operation
// transfers on a rising edge where both are 1. op_ready is 1 only in IDLE.
// op_valid seen while busy is ignored, not queued.
//
// Build option: define PERMUTE_RD_BYPASS_EN to forward data_w onto data_r
// when an accepted external write targets the address being read. Without
// it, data_r shows the stored contents until the edge. Sequential behaviour
// is the same in both builds.
//
// Ports:
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   write_en   external write strobe
//   address_w  external write address
//   data_w     external write data
//   address_r  read address
//   data_r     read data (combinational)
//   op_valid   permute request
//   op_ready   idle, accepting a request
//   op_mode    00 SWAP A<->B, 01 COPY A->B, 10 CLEAR B, 11 reserved
//   address_A  operand address A
//   address_B  operand address B
//   op_done    one-cycle pulse after the COMMIT edge
//   op_err     one-cycle pulse with op_done for the reserved mode
//   wr_drop    one-cycle pulse after an external write was discarded
module permute_reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] address_w,
  input  logic [DATA_WIDTH-1:0] data_w,
  input  logic [ADDR_WIDTH-1:0] address_r,
  output logic [DATA_WIDTH-1:0] data_r,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_mode,
  input  logic [ADDR_WIDTH-1:0] address_A,
  input  logic [ADDR_WIDTH-1:0] address_B,
  output logic                  op_done,
  output logic                  op_err,
  output logic                  wr_drop
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] MODE_SWAP  = 2'b00;
  localparam logic [1:0] MODE_COPY  = 2'b01;
  localparam logic [1:0] MODE_CLEAR = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] tmp_a;
  logic [DATA_WIDTH-1:0] tmp_b;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;

  logic                  op_accept;
  logic                  wr_ok;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state and op_ready
  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    case (state)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) state_nxt = LATCH;
      end
      LATCH:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign op_accept = op_valid && op_ready;
  assign wr_ok     = write_en && op_ready;

  // Operation fields, operand capture and status pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= MODE_SWAP;
      addr_a_q <= '0;
      addr_b_q <= '0;
      tmp_a    <= '0;
      tmp_b    <= '0;
      op_done  <= 1'b0;
      op_err   <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      if (op_accept) begin
        mode_q   <= op_mode;
        addr_a_q <= address_A;
        addr_b_q <= address_B;
      end
      // The write accepted on the accept edge has already landed by now,
      // so the operands reflect it.
      if (state == LATCH) begin
        tmp_a <= mem[addr_a_q];
        tmp_b <= mem[addr_b_q];
      end
      op_done <= (state == COMMIT);
      op_err  <= (state == COMMIT) && (mode_q == MODE_RSVD);
      wr_drop <= write_en && !op_ready;
    end
  end

  // Storage array. External writes and the commit never coincide because
  // writes are only taken in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '{default: '0};
    end else begin
      if (wr_ok) begin
        mem[address_w] <= data_w;
      end
      if (state == COMMIT) begin
        case (mode_q)
          MODE_SWAP: begin
            // With A == B both writes carry the same value.
            mem[addr_a_q] <= tmp_b;
            mem[addr_b_q] <= tmp_a;
          end
          MODE_COPY:  mem[addr_b_q] <= tmp_a;
          MODE_CLEAR: mem[addr_b_q] <= '0;
          default: ;
        endcase
      end
    end
  end

  // Read port
`ifdef PERMUTE_RD_BYPASS_EN
  assign data_r = (wr_ok && (address_w == address_r)) ? data_w : mem[address_r];
`else
  assign data_r = mem[address_r];
`endif

endmodule
